// File: rtl/wb_scoreboard.sv
// End-of-test checker: shadows the core's register writeback port, bounds the run by
// halt or a cycle budget, then scans programmed expected values into a sticky verdict.
module wb_scoreboard #(
  parameter int  XLEN         = 32,
  parameter int  NUM_CHECKS   = 8,
  parameter int  START_DELAY  = 5,
  parameter int  MAX_CYCLES   = 20,
  parameter bit  REQUIRE_HALT = 1'b0,
  parameter int  CW           = 32,
  localparam int IW           = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            halt,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic            cfg_en,
  input  logic [4:0]      cfg_rd,
  input  logic [XLEN-1:0] cfg_val,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [1:0]      fail_code,
  output logic [IW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_got,
  output logic [CW-1:0]   cycle_count
);

  localparam int SW = $clog2(NUM_CHECKS + 1);
  localparam int DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

  typedef enum logic [1:0] {WAIT, RUN, CHECK, DONE} state_t;

  // Named state signal kept visible for external checkers.
  state_t          state;
  logic [DW-1:0]   dly_cnt;
  logic [SW-1:0]   scan_idx;
  logic [XLEN-1:0] shadow   [32];
  logic            slot_en  [NUM_CHECKS];
  logic [4:0]      slot_rd  [NUM_CHECKS];
  logic [XLEN-1:0] slot_val [NUM_CHECKS];

  logic            live;
  logic [IW-1:0]   scan_slot;
  logic            scan_last;
  logic [XLEN-1:0] scan_got;
  logic            scan_miss;

  assign live      = (state == WAIT) || (state == RUN);
  assign scan_slot = scan_idx[IW-1:0];
  // One extra scan step past the last slot issues the pass verdict.
  assign scan_last = (int'(scan_idx) == NUM_CHECKS);
  assign scan_got  = shadow[slot_rd[scan_slot]];
  assign scan_miss = slot_en[scan_slot] && (scan_got != slot_val[scan_slot]);

  // wb_valid and cfg_we are one-cycle strobes with no backpressure: every strobe
  // seen while live is consumed on that edge, otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        slot_en[i]  <= 1'b0;
        slot_rd[i]  <= '0;
        slot_val[i] <= '0;
      end
    end else if (live) begin
      if (wb_valid && (wb_rd != 5'd0)) shadow[wb_rd] <= wb_data;
      if (cfg_we && (int'(cfg_idx) < NUM_CHECKS)) begin
        slot_en[cfg_idx]  <= cfg_en;
        slot_rd[cfg_idx]  <= cfg_rd;
        slot_val[cfg_idx] <= cfg_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT;
      dly_cnt     <= '0;
      scan_idx    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      fail_idx    <= '0;
      fail_got    <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        WAIT: begin
          if (dly_cnt == DW'(START_DELAY)) state <= RUN;
          else                             dly_cnt <= dly_cnt + DW'(1);
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + CW'(1);
          if (halt) begin
            state    <= CHECK;
            scan_idx <= '0;
          end else if (cycle_count == CW'(MAX_CYCLES - 1)) begin
            if (REQUIRE_HALT) begin
              state     <= DONE;
              done      <= 1'b1;
              fail      <= 1'b1;
              fail_code <= 2'd2;
            end else begin
              state    <= CHECK;
              scan_idx <= '0;
            end
          end
        end
        CHECK: begin
          if (scan_last) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else if (scan_miss) begin
            state     <= DONE;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= 2'd1;
            fail_idx  <= scan_slot;
            fail_got  <= scan_got;
          end else begin
            scan_idx <= scan_idx + SW'(1);
          end
        end
        DONE: state <= DONE;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: two instances share stimulus, one lets budget expiry end
// the run normally, the other treats it as a timeout; verdicts come from a slot model.
module tb_wb_scoreboard;

  localparam int N  = 8;
  localparam int D  = 5;
  localparam int MC = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid, halt, cfg_we, cfg_en;
  logic [4:0]  wb_rd, cfg_rd;
  logic [31:0] wb_data, cfg_val;
  logic [2:0]  cfg_idx;

  logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
  logic [1:0]  a_code, b_code;
  logic [2:0]  a_idx, b_idx;
  logic [31:0] a_got, b_got, a_cc, b_cc;

  logic [31:0] m_shadow [32];
  logic        m_en  [N];
  logic [4:0]  m_rd  [N];
  logic [31:0] m_val [N];
  logic [36:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_scoreboard #(.XLEN(32), .NUM_CHECKS(N), .START_DELAY(D), .MAX_CYCLES(MC),
                  .REQUIRE_HALT(1'b0), .CW(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .halt(halt), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_rd(cfg_rd),
    .cfg_val(cfg_val), .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
    .fail_idx(a_idx), .fail_got(a_got), .cycle_count(a_cc));

  wb_scoreboard #(.XLEN(32), .NUM_CHECKS(N), .START_DELAY(D), .MAX_CYCLES(MC),
                  .REQUIRE_HALT(1'b1), .CW(32)) dut_rh (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .halt(halt), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_rd(cfg_rd),
    .cfg_val(cfg_val), .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
    .fail_idx(b_idx), .fail_got(b_got), .cycle_count(b_cc));

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; wb_valid = 0; wb_rd = 0; wb_data = 0; halt = 0;
    cfg_we = 0; cfg_idx = 0; cfg_en = 0; cfg_rd = 0; cfg_val = 0;
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
    for (int i = 0; i < N; i++) begin m_en[i] = 0; m_rd[i] = 0; m_val[i] = 0; end
    #7; @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_rd = rd; wb_data = d;
    step();
    wb_valid = 0;
    if (rd != 0) m_shadow[rd] = d;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [4:0] rd,
                           input logic [31:0] v);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_en = en; cfg_rd = rd; cfg_val = v;
    step();
    cfg_we = 0;
    m_en[idx] = en; m_rd[idx] = rd; m_val[idx] = v;
  endtask

  task automatic do_halt(input bit with_wb, input logic [4:0] rd, input logic [31:0] d);
    halt = 1;
    if (with_wb) begin wb_valid = 1; wb_rd = rd; wb_data = d; end
    step();
    halt = 0; wb_valid = 0;
    if (with_wb && rd != 0) m_shadow[rd] = d;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 50; n++) begin
      step();
      if (a_done) begin lat = n; break; end
    end
  endtask

  // Reference: first enabled slot whose register disagrees decides the verdict.
  task automatic predict(output logic [1:0] code, output logic [2:0] idx,
                         output logic [31:0] got, output int lat);
    code = 0; idx = 0; got = 0; lat = N + 1;
    for (int s = 0; s < N; s++) begin
      if (m_en[s] && m_shadow[m_rd[s]] != m_val[s]) begin
        code = 1; idx = 3'(s); got = m_shadow[m_rd[s]]; lat = s + 1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    if ({a_done, a_pass, a_fail, a_code, a_idx, a_got, a_cc} !== '0) begin
      n_err++; $display("FAIL reset_a: got %h exp 0", {a_done, a_pass, a_fail, a_code, a_idx, a_got, a_cc});
    end
    n_cmp++;
    if ({b_done, b_pass, b_fail, b_code, b_idx, b_got, b_cc} !== '0) begin
      n_err++; $display("FAIL reset_b: got %h exp 0", {b_done, b_pass, b_fail, b_code, b_idx, b_got, b_cc});
    end
    n_cmp++;
  endtask

  task automatic test_pass();
    int lat;
    reset_dut();
    cfg_write(0, 1, 5'd1, 32'd5); cfg_write(1, 1, 5'd2, 32'd12); cfg_write(2, 1, 5'd3, 32'd17);
    wb_write(5'd1, 32'd5); wb_write(5'd2, 32'd12); wb_write(5'd3, 32'd17);
    repeat (4) step();
    do_halt(0, 5'd0, 32'd0);
    wait_done(lat);
    if (lat !== N + 1) begin n_err++; $display("FAIL pass_latency: got %0d exp %0d", lat, N + 1); end
    n_cmp++;
    if ({a_pass, a_fail, a_code} !== 4'b1000) begin
      n_err++; $display("FAIL pass_verdict: got %b exp 1000", {a_pass, a_fail, a_code});
    end
    n_cmp++;
    if ({b_done, b_pass, b_code} !== 4'b1100) begin
      n_err++; $display("FAIL pass_verdict_rh: got %b exp 1100", {b_done, b_pass, b_code});
    end
    n_cmp++;
  endtask

  task automatic test_mismatch();
    int lat;
    reset_dut();
    cfg_write(0, 1, 5'd1, 32'd5); cfg_write(1, 1, 5'd2, 32'd12); cfg_write(2, 1, 5'd3, 32'd17);
    wb_write(5'd1, 32'd5); wb_write(5'd2, 32'd11); wb_write(5'd3, 32'd17);
    repeat (4) step();
    do_halt(0, 5'd0, 32'd0);
    wait_done(lat);
    if (lat !== 2) begin n_err++; $display("FAIL mismatch_latency: got %0d exp 2", lat); end
    n_cmp++;
    if ({a_pass, a_fail, a_code, a_idx} !== {1'b0, 1'b1, 2'd1, 3'd1}) begin
      n_err++; $display("FAIL mismatch_verdict: got p%b f%b c%0d i%0d exp p0 f1 c1 i1", a_pass, a_fail, a_code, a_idx);
    end
    n_cmp++;
    if (a_got !== 32'd11) begin n_err++; $display("FAIL mismatch_got: got %0d exp 11", a_got); end
    n_cmp++;
  endtask

  task automatic test_timeout();
    int lat;
    int n;
    reset_dut();
    cfg_write(0, 1, 5'd1, 32'd5);
    wb_write(5'd1, 32'd5);
    n = 0;
    while (!b_done && n < 80) begin step(); n++; end
    if ({b_done, b_fail, b_pass, b_code} !== 5'b11010) begin
      n_err++; $display("FAIL timeout_verdict: got %b exp 11010", {b_done, b_fail, b_pass, b_code});
    end
    n_cmp++;
    if (b_cc !== 32'(MC)) begin n_err++; $display("FAIL timeout_cycles: got %0d exp %0d", b_cc, MC); end
    n_cmp++;
    wait_done(lat);
    if (lat !== N + 1) begin n_err++; $display("FAIL budget_check_latency: got %0d exp %0d", lat, N + 1); end
    n_cmp++;
    if ({a_pass, a_fail, a_cc} !== {1'b1, 1'b0, 32'(MC)}) begin
      n_err++; $display("FAIL budget_pass: got p%b f%b cc%0d exp p1 f0 cc%0d", a_pass, a_fail, a_cc, MC);
    end
    n_cmp++;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'd9;
    step();
    wb_valid = 0;
    repeat (3) step();
    if ({b_done, b_fail, b_code, b_idx, b_got, b_cc} !== {1'b1, 1'b1, 2'd2, 3'd0, 32'd0, 32'(MC)}) begin
      n_err++; $display("FAIL timeout_hold: got c%0d cc%0d got%0d exp c2 cc%0d got0", b_code, b_cc, b_got, MC);
    end
    n_cmp++;
    if ({a_done, a_pass, a_cc} !== {1'b1, 1'b1, 32'(MC)}) begin
      n_err++; $display("FAIL done_hold: got d%b p%b cc%0d exp d1 p1 cc%0d", a_done, a_pass, a_cc, MC);
    end
    n_cmp++;
  endtask

  task automatic test_x0();
    int lat;
    logic [1:0] c; logic [2:0] i; logic [31:0] g; int el;
    reset_dut();
    wb_write(5'd0, 32'd7);
    cfg_write(0, 1, 5'd0, 32'd0);
    repeat (7) step();
    do_halt(0, 5'd0, 32'd0);
    predict(c, i, g, el);
    wait_done(lat);
    if ({lat, a_pass, a_code} !== {el, c == 2'd0, c}) begin
      n_err++; $display("FAIL x0_write: got lat%0d p%b c%0d exp lat%0d c%0d", lat, a_pass, a_code, el, c);
    end
    n_cmp++;
  endtask

  task automatic test_halt_wb();
    int lat;
    reset_dut();
    cfg_write(0, 1, 5'd3, 32'd17);
    repeat (7) step();
    do_halt(1, 5'd3, 32'd17);
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'd99;
    step();
    wb_valid = 0;
    lat = -1;
    for (int n = 2; n <= 50; n++) begin
      if (a_done) begin lat = n - 1; break; end
      step();
    end
    if ({lat, a_pass, a_fail} !== {N + 1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL halt_same_cycle_wb: got lat%0d p%b f%b exp lat%0d p1 f0", lat, a_pass, a_fail, N + 1);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_check();
    int lat;
    reset_dut();
    cfg_write(0, 1, 5'd1, 32'd5);
    repeat (7) step();
    do_halt(0, 5'd0, 32'd0);
    step();
    rst_n = 1'b0;
    #1;
    if ({a_done, a_pass, a_fail, a_code, a_idx, a_got, a_cc} !== '0) begin
      n_err++; $display("FAIL async_reset: got cc%0d d%b f%b exp all 0", a_cc, a_done, a_fail);
    end
    n_cmp++;
    #3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < N; s++) m_en[s] = 0;
    repeat (8) step();
    do_halt(0, 5'd0, 32'd0);
    wait_done(lat);
    if ({lat, a_pass, a_fail} !== {N + 1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL rerun_after_reset: got lat%0d p%b f%b exp lat%0d p1 f0", lat, a_pass, a_fail, N + 1);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    int lat, el;
    logic [1:0] c; logic [2:0] i; logic [31:0] g;
    logic [36:0] exp_v;
    logic [4:0] r;
    for (int it = 0; it < 8; it++) begin
      reset_dut();
      for (int w = 0; w < 4; w++) wb_write(5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)));
      for (int s = 0; s < N; s++) begin
        r = 5'($urandom_range(0, 7));
        cfg_write(s, $urandom_range(0, 3) != 0, r,
                  ($urandom_range(0, 4) != 0) ? m_shadow[r] : 32'($urandom_range(0, 3)));
      end
      do_halt($urandom_range(0, 1) == 1, 5'($urandom_range(1, 7)), 32'($urandom_range(0, 3)));
      predict(c, i, g, el);
      exp_q.push_back({c, i, g});
      wb_valid = 1; wb_rd = 5'($urandom_range(1, 7)); wb_data = 32'($urandom_range(4, 9));
      step();
      wb_valid = 0;
      lat = -1;
      for (int n = 2; n <= 50; n++) begin
        if (a_done) begin lat = n - 1; break; end
        step();
      end
      if (lat !== el) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", it, lat, el); end
      n_cmp++;
      exp_v = exp_q.pop_front();
      if ({a_code, a_idx, a_got} !== exp_v) begin
        n_err++; $display("FAIL rand_verdict[%0d]: got c%0d i%0d g%0d exp c%0d i%0d g%0d",
                          it, a_code, a_idx, a_got, exp_v[36:35], exp_v[34:32], exp_v[31:0]);
      end
      n_cmp++;
      if ({a_pass, a_fail, b_code} !== {exp_v[36:35] == 2'd0, exp_v[36:35] != 2'd0, exp_v[36:35]}) begin
        n_err++; $display("FAIL rand_flags[%0d]: got p%b f%b bc%0d exp c%0d", it, a_pass, a_fail, b_code, exp_v[36:35]);
      end
      n_cmp++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_x0();
    test_halt_wb();
    test_reset_mid_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Parametrised end-of-test checker for core simulations. It shadows the core's register-file writeback port and bounds the run with a cycle budget or a halt event. At end of run it compares up to NUM_CHECKS programmed expected register values and raises a sticky pass or fail verdict with failure detail. It sits beside the core in the simulation top and replaces the fixed-delay, fixed-register checks with a reusable, per-program configurable block.

## Interface
- XLEN, 32, data width of writeback and expected values
- NUM_CHECKS, 8, number of expected-value slots (≥1)
- START_DELAY, 5, cycles after reset release before the cycle budget starts
- MAX_CYCLES, 20, run budget in cycles after START_DELAY (≥1)
- REQUIRE_HALT, 0, 1: reaching MAX_CYCLES without halt is a timeout failure; 0: budget expiry ends the run normally
- CW, 32, width of cycle_count

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  writeback strobe from core
- wb_rd  in  5  destination register
- wb_data  in  XLEN  writeback value
- halt  in  1  core retired ecall/ebreak; ends run
- cfg_we  in  1  write one expected-value slot
- cfg_idx  in  $clog2(NUM_CHECKS) (min 1)  slot index
- cfg_en  in  1  slot enable
- cfg_rd  in  5  register checked by slot
- cfg_val  in  XLEN  expected value
- done  out  1  verdict valid (sticky)
- pass  out  1  all enabled slots matched, no timeout (sticky)
- fail  out  1  mismatch or timeout (sticky)
- fail_code  out  2  0 none, 1 mismatch, 2 timeout
- fail_idx  out  $clog2(NUM_CHECKS)  first mismatching slot
- fail_got  out  XLEN  shadow value of first mismatching slot
- cycle_count  out  CW  cycles spent in RUN

## Operation
- States: WAIT, RUN, CHECK, DONE.
- Reset (async): state WAIT. Shadow registers and all slots cleared, with slot enable 0. All outputs 0.
- WAIT: a delay counter counts START_DELAY cycles, then the block enters RUN. START_DELAY=0 enters RUN on the first edge after reset release.
- Shadow file: 32×XLEN. A write with wb_valid and wb_rd≠0 updates the entry in WAIT and RUN. Writes to x0 are dropped and shadow[0] stays 0. Writebacks are ignored in CHECK and DONE.
- RUN: cycle_count increments each cycle. Leaving RUN:
  - halt=1 goes to CHECK, with the same-cycle writeback applied first.
  - cycle_count reaching MAX_CYCLES−1 while halt=0 goes to CHECK if REQUIRE_HALT=0.
  - In the same case with REQUIRE_HALT=1, the block goes to DONE with fail, fail_code=2.
  - halt in WAIT is ignored.
- Config: cfg_we writes slot cfg_idx {en, rd, val} in WAIT and RUN. It is ignored in CHECK and DONE. An out-of-range cfg_idx is ignored.
- CHECK: a scan index starts at 0 and visits one slot per cycle.
  - An enabled slot whose shadow[rd] is not equal to val ends the scan. The block goes to DONE with fail, fail_code=1, fail_idx=slot and fail_got=shadow value.
  - Disabled slots are skipped but still cost one cycle.
  - After slot NUM_CHECKS−1 with no mismatch, the block goes to DONE with pass.
- DONE: the state is terminal until reset. done, pass, fail, fail_code, fail_idx, fail_got and cycle_count hold.
- pass and fail are never both 1. done equals pass OR fail.
- cycle_count saturates at all-ones and does not wrap.

## Timing
- Verdict latency after halt is sampled: NUM_CHECKS+1 cycles to done=1 on pass. A mismatch at slot k gives k+1 cycles.
- A timeout asserts done on the edge after the final budget cycle.
- Outputs are registered. There are no combinational input-to-output paths.
- An asynchronous rst_n assertion mid-RUN or mid-CHECK clears everything immediately. A new run restarts from WAIT after release.
- A cfg_we and writeback on the same cycle are both applied. A cfg write and scan on the same slot cannot occur, because config is blocked in CHECK.

## Test plan
- Slots 0..2 = {x1=5, x2=12, x3=17}. Writebacks x1=5, x2=12, x3=17, then halt → pass=1, fail_code=0, done NUM_CHECKS+1 cycles after halt.
- Same slots, but x2 written 11 → fail=1, fail_code=1, fail_idx=1, fail_got=11, done 2 cycles after halt.
- REQUIRE_HALT=1, MAX_CYCLES=20, no halt → fail_code=2 with cycle_count=20. Any later writeback leaves state unchanged.
- REQUIRE_HALT=0, no halt, slot x1=5 satisfied → CHECK entered after 20 RUN cycles, then pass. A write to x0 of 7 plus slot x0=0 → pass.
- Writeback in the same cycle as halt (x3=17) is counted. A writeback one cycle after halt (x3=99) is ignored → pass.
- rst_n pulsed low mid-CHECK → all outputs 0 asynchronously, slots disabled. A rerun with no slots enabled → pass.
